// File: rtl/ootx_pkg.sv
// ootx_pkg: state encoding, register map and read default shared by the OOTX sensor scheduler
package ootx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        DWELL  = 2'd2,
        NEXT   = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_MASK       = 4'd1;
    localparam logic [3:0] ADDR_TIMEOUT    = 4'd2;
    localparam logic [3:0] ADDR_STATUS     = 4'd3;
    localparam logic [3:0] ADDR_FOUND0     = 4'd4;
    localparam logic [3:0] ADDR_FOUND1     = 4'd5;
    localparam logic [3:0] ADDR_SCAN_COUNT = 4'd6;
    localparam logic [3:0] ADDR_CLEAR      = 4'd7;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/ootx_sensor_scheduler_next_set_bit.sv
// next_set_bit: finds the next enabled sensor above the current one and the lowest enabled sensor
module next_set_bit #(
    parameter int NUMBER_OF_SENSORS = 8,
    parameter int SEL_W = 5
) (
    input  logic [NUMBER_OF_SENSORS-1:0] mask_i,
    input  logic [SEL_W-1:0]             cur_i,
    output logic [SEL_W-1:0]             nxt_o,
    output logic [SEL_W-1:0]             wrap_o,
    output logic                         none_o
);

    // Scan downwards so the lowest qualifying bit is the last one written
    always_comb begin
        nxt_o  = '0;
        wrap_o = '0;
        none_o = 1'b1;
        for (int i = NUMBER_OF_SENSORS - 1; i >= 0; i--) begin
            if (mask_i[i]) wrap_o = SEL_W'(i);
            if (mask_i[i] && i > int'(cur_i)) begin
                nxt_o  = SEL_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ootx_sensor_scheduler.sv
// ootx_sensor_scheduler: walks the sensor mask, dwelling on each channel until both lighthouses decode or a timeout hits
module ootx_sensor_scheduler
    import ootx_pkg::*;
#(
    parameter int          NUMBER_OF_SENSORS = 8,
    parameter int          SEL_W             = 5,
    parameter logic [31:0] DEFAULT_TIMEOUT   = 32'd400_000_000,
    parameter int          SETTLE_CYCLES     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       address,
    input  logic             read,
    output logic [31:0]      readdata,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic             waitrequest,
    input  logic [1:0]       sync,
    output logic [SEL_W-1:0] sensor_select,
    output logic             decoder_flush,
    output logic             scan_done
);

    localparam int N = NUMBER_OF_SENSORS;

    state_t           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [31:0]      timeout_q, timeout_d;
    logic [N-1:0]     found0_q, found0_d;
    logic [N-1:0]     found1_q, found1_d;
    logic [31:0]      scan_count_q, scan_count_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       seen_q, seen_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] nxt, wrap;
    logic [1:0]       seen_w;
    logic [N-1:0]     sel_bit;
    logic             none, en, cont, upd, pass_done, timed_out, wr_clear, mask_empty;
    logic             unused_bits;

    assign en          = ctrl_q[0];
    assign cont        = ctrl_q[1];
    assign seen_w      = seen_q | sync;
    assign sel_bit     = N'(1) << sel_q;
    assign upd         = state_q == NEXT && en;
    assign pass_done   = upd && none;
    assign timed_out   = timeout_q != '0 && cnt_q >= timeout_q - 32'd1;
    assign wr_clear    = write && address == ADDR_CLEAR;
    assign mask_empty  = state_q == IDLE && en && mask_q == '0;
    assign unused_bits = ^{read, writedata};

    next_set_bit #(
        .NUMBER_OF_SENSORS(N),
        .SEL_W(SEL_W)
    ) u_next_set_bit (
        .mask_i(mask_q),
        .cur_i(sel_q),
        .nxt_o(nxt),
        .wrap_o(wrap),
        .none_o(none)
    );

    // FSM state register; async reset also drops decoder_flush immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; a cleared enable aborts from any active state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (en && mask_q != '0) state_d = SWITCH;
            SWITCH: state_d = !en ? IDLE : (cnt_q == 32'(SETTLE_CYCLES - 1)) ? DWELL : SWITCH;
            DWELL:  state_d = !en ? IDLE : (seen_w == 2'b11 || timed_out) ? NEXT : DWELL;
            NEXT:   state_d = (!en || (none && (!cont || mask_q == '0))) ? IDLE : SWITCH;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        decoder_flush = state_q == SWITCH;
        scan_done     = pass_done;
        sensor_select = sel_q;
        waitrequest   = 1'b0;
    end

    // Datapath next state: host writes, found bookkeeping, counters and channel choice
    always_comb begin
        ctrl_d = ctrl_q;
        if (pass_done && !cont) ctrl_d[0] = 1'b0;
        if (write && address == ADDR_CTRL) ctrl_d = writedata[1:0];
        mask_d       = (write && address == ADDR_MASK) ? writedata[N-1:0] : mask_q;
        timeout_d    = (write && address == ADDR_TIMEOUT) ? writedata : timeout_q;
        found0_d     = wr_clear ? '0 : found0_q | ((upd && seen_w[0]) ? sel_bit : '0);
        found1_d     = wr_clear ? '0 : found1_q | ((upd && seen_w[1]) ? sel_bit : '0);
        scan_count_d = wr_clear ? '0 : scan_count_q + 32'(pass_done);
        seen_d       = (state_q == DWELL && en) ? seen_w : 2'b00;
        cnt_d        = (state_d == state_q && state_q != IDLE) ? cnt_q + 32'd1 : '0;
        sel_d        = (state_d == SWITCH && state_q != SWITCH) ? ((state_q == NEXT && !none) ? nxt : wrap) : sel_q;
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            mask_q       <= '1;
            timeout_q    <= DEFAULT_TIMEOUT;
            found0_q     <= '0;
            found1_q     <= '0;
            scan_count_q <= '0;
            cnt_q        <= '0;
            seen_q       <= '0;
            sel_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            mask_q       <= mask_d;
            timeout_q    <= timeout_d;
            found0_q     <= found0_d;
            found1_q     <= found1_d;
            scan_count_q <= scan_count_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            sel_q        <= sel_d;
        end
    end

    // Avalon read mux, combinational from address
    always_comb begin
        case (address)
            ADDR_CTRL:       readdata = {30'd0, ctrl_q};
            ADDR_MASK:       readdata = 32'(mask_q);
            ADDR_TIMEOUT:    readdata = timeout_q;
            ADDR_STATUS:     readdata = {11'd0, mask_empty, 2'd0, seen_q, 3'd0, 5'(sel_q), 6'd0, state_q};
            ADDR_FOUND0:     readdata = 32'(found0_q);
            ADDR_FOUND1:     readdata = 32'(found1_q);
            ADDR_SCAN_COUNT: readdata = scan_count_q;
            ADDR_CLEAR:      readdata = '0;
            default:         readdata = DEADBEEF;
        endcase
    end

endmodule

// File: tb/tb_ootx_sensor_scheduler.sv
// tb_ootx_sensor_scheduler: directed scenarios checked every cycle against a behavioural scheduler model
module tb_ootx_sensor_scheduler;

    localparam int N      = 8;
    localparam int SETTLE = 16;
    localparam int DEF_TO = 400000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [1:0]  sync = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [4:0]  sensor_select;
    logic        decoder_flush;
    logic        scan_done;

    int checks = 0;
    int passes = 0;

    ootx_sensor_scheduler #(
        .NUMBER_OF_SENSORS(N),
        .SEL_W(5),
        .DEFAULT_TIMEOUT(32'(DEF_TO)),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .read(read),
        .readdata(readdata),
        .write(write),
        .writedata(writedata),
        .waitrequest(waitrequest),
        .sync(sync),
        .sensor_select(sensor_select),
        .decoder_flush(decoder_flush),
        .scan_done(scan_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Behavioural model: phase 0 idle, 1 settling, 2 listening, 3 bookkeeping
    int          m_ph, m_sel, m_left, m_scans;
    logic [31:0] m_to, m_el;
    logic [1:0]  m_seen, m_ctrl;
    logic [N-1:0] m_mask, m_f0, m_f1;

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int above(input logic [N-1:0] m, input int s);
        for (int i = s + 1; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin : model_step
        logic [1:0] c;
        logic [1:0] s;
        int nx;
        if (reset) begin
            m_ph = 0; m_sel = 0; m_left = 0; m_el = 0; m_to = 32'(DEF_TO); m_scans = 0;
            m_seen = 0; m_ctrl = 0; m_mask = '1; m_f0 = 0; m_f1 = 0;
        end else begin
            c = m_ctrl;
            case (m_ph)
                0: if (m_ctrl[0] && m_mask != 0) begin
                    m_ph = 1; m_sel = lowest(m_mask); m_left = SETTLE;
                end
                1: if (!m_ctrl[0]) m_ph = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin m_ph = 2; m_el = 0; end
                   end
                2: if (!m_ctrl[0]) begin m_ph = 0; m_seen = 0; end
                   else begin
                       m_seen = m_seen | sync;
                       m_el = m_el + 1;
                       if (m_seen == 2'b11 || (m_to != 0 && m_el >= m_to)) m_ph = 3;
                   end
                default: begin
                    if (m_ctrl[0]) begin
                        s = m_seen | sync;
                        if (s[0]) m_f0[m_sel] = 1'b1;
                        if (s[1]) m_f1[m_sel] = 1'b1;
                        nx = above(m_mask, m_sel);
                        if (nx >= 0) begin m_sel = nx; m_ph = 1; m_left = SETTLE; end
                        else begin
                            m_scans++;
                            if (m_ctrl[1] && m_mask != 0) begin m_sel = lowest(m_mask); m_ph = 1; m_left = SETTLE; end
                            else begin m_ph = 0; if (!m_ctrl[1]) c[0] = 1'b0; end
                        end
                    end else m_ph = 0;
                    m_seen = 0;
                end
            endcase
            if (write && address == 4'd0) c = writedata[1:0];
            if (write && address == 4'd1) m_mask = writedata[N-1:0];
            if (write && address == 4'd2) m_to = writedata;
            m_ctrl = c;
            if (write && address == 4'd7) begin m_f0 = 0; m_f1 = 0; m_scans = 0; end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            4'd0: r = 32'(m_ctrl);
            4'd1: r = 32'(m_mask);
            4'd2: r = m_to;
            4'd3: begin
                r[1:0]   = m_ph[1:0];
                r[12:8]  = m_sel[4:0];
                r[17:16] = m_seen;
                r[20]    = m_ph == 0 && m_ctrl[0] && m_mask == 0;
            end
            4'd4: r = 32'(m_f0);
            4'd5: r = 32'(m_f1);
            4'd6: r = 32'(m_scans);
            4'd7: r = '0;
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(posedge clock) begin
        #1;
        check("sensor_select", 32'(sensor_select), 32'(m_sel));
        check("decoder_flush", 32'(decoder_flush), 32'(m_ph == 1));
        check("scan_done", 32'(scan_done), 32'(m_ph == 3 && m_ctrl[0] && above(m_mask, m_sel) < 0));
        check("readdata", readdata, exp_rd(address));
        check("waitrequest", 32'(waitrequest), 32'd0);
    end

    // Observation of flush run lengths, selected channels and dwell length before scan_done
    logic prev_flush = 1'b0;
    int run = 0, gap = 0, last_gap = -1, done_cnt = 0;
    int runs[$];
    int sels[$];

    always @(posedge clock) begin
        #1;
        if (decoder_flush && !prev_flush) sels.push_back(int'(sensor_select));
        if (decoder_flush) begin
            run++;
            gap = 0;
        end else begin
            if (prev_flush) begin runs.push_back(run); run = 0; end
            if (scan_done) begin last_gap = gap; done_cnt++; end
            else gap++;
        end
        prev_flush = decoder_flush;
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clock);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic wait_ph(input int p, input int budget, input string nm);
        int n = 0;
        while (m_ph != p && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(nm, 32'(m_ph == p), 32'd1);
    endtask

    int exp_seq[7] = '{0, 7, 0, 7, 0, 7, 0};

    initial begin
        logic [31:0] v;
        repeat (3) @(negedge clock);
        check("rst sensor_select", 32'(sensor_select), 32'd0);
        check("rst decoder_flush", 32'(decoder_flush), 32'd0);
        check("rst scan_done", 32'(scan_done), 32'd0);
        reset = 1'b0;
        rd(4'd0, v); check("rst ctrl", v, 32'd0);
        rd(4'd1, v); check("rst mask", v, 32'h0000_00FF);
        rd(4'd2, v); check("rst timeout", v, 32'd400000000);
        rd(4'd3, v); check("rst status", v, 32'd0);
        rd(4'd4, v); check("rst found0", v, 32'd0);
        rd(4'd6, v); check("rst scan_count", v, 32'd0);

        // Single pass over sensors 0 and 2, lighthouses arriving one at a time
        bus_wr(4'd2, 32'd0);
        bus_wr(4'd1, 32'h05);
        runs.delete(); sels.delete(); done_cnt = 0;
        bus_wr(4'd0, 32'd1);
        repeat (2) begin
            wait_ph(2, 200, "t1 reach dwell");
            sync = 2'b01;
            @(negedge clock); sync = 2'b00;
            repeat (3) @(negedge clock);
            sync = 2'b10;
            @(negedge clock); sync = 2'b00;
        end
        wait_ph(0, 200, "t1 reach idle");
        check("t1 switch count", 32'(runs.size()), 32'd2);
        check("t1 flush len0", 32'(runs.size() > 0 ? runs[0] : -1), 32'd16);
        check("t1 flush len1", 32'(runs.size() > 1 ? runs[1] : -1), 32'd16);
        check("t1 sel0", 32'(sels.size() > 0 ? sels[0] : 99), 32'd0);
        check("t1 sel1", 32'(sels.size() > 1 ? sels[1] : 99), 32'd2);
        check("t1 scan_done pulses", 32'(done_cnt), 32'd1);
        rd(4'd4, v); check("t1 found0", v, 32'h05);
        rd(4'd5, v); check("t1 found1", v, 32'h05);
        rd(4'd6, v); check("t1 scan_count", v, 32'd1);
        rd(4'd0, v); check("t1 ctrl", v, 32'd0);

        // Timeout-only dwell on sensor 0
        bus_wr(4'd7, 32'd0);
        bus_wr(4'd2, 32'd100);
        bus_wr(4'd1, 32'h01);
        done_cnt = 0; last_gap = -1;
        bus_wr(4'd0, 32'd1);
        wait_ph(2, 100, "t2 reach dwell");
        wait_ph(0, 300, "t2 reach idle");
        check("t2 dwell length", 32'(last_gap), 32'd100);
        check("t2 scan_done pulses", 32'(done_cnt), 32'd1);
        rd(4'd4, v); check("t2 found0", v, 32'd0);
        rd(4'd5, v); check("t2 found1", v, 32'd0);
        rd(4'd6, v); check("t2 scan_count", v, 32'd1);

        // Both lighthouses in one clock on sensor 3
        bus_wr(4'd2, 32'd0);
        bus_wr(4'd1, 32'h08);
        bus_wr(4'd0, 32'd1);
        wait_ph(2, 100, "t3 reach dwell");
        repeat (2) @(negedge clock);
        sync = 2'b11;
        @(posedge clock); #1;
        check("t3 next after dual sync", 32'(scan_done), 32'd1);
        @(negedge clock); sync = 2'b00;
        wait_ph(0, 10, "t3 reach idle");
        rd(4'd4, v); check("t3 found0", v, 32'h08);
        rd(4'd5, v); check("t3 found1", v, 32'h08);
        rd(4'd6, v); check("t3 scan_count", v, 32'd2);

        // Clear
        bus_wr(4'd7, 32'd0);
        rd(4'd4, v); check("clr found0", v, 32'd0);
        rd(4'd5, v); check("clr found1", v, 32'd0);
        rd(4'd6, v); check("clr scan_count", v, 32'd0);

        // Continuous scanning of sensors 0 and 7, then abort mid-dwell
        bus_wr(4'd2, 32'd20);
        bus_wr(4'd1, 32'h81);
        sels.delete(); done_cnt = 0;
        bus_wr(4'd0, 32'd3);
        for (int n = 0; n < 2000 && done_cnt < 3; n++) @(negedge clock);
        check("t4 passes", 32'(done_cnt), 32'd3);
        wait_ph(2, 100, "t4 reach dwell");
        repeat (5) @(negedge clock);
        bus_wr(4'd0, 32'd0);
        address = 4'd3;
        #1;
        check("t4 still dwell", 32'(readdata[1:0]), 32'd2);
        rd(4'd3, v);
        check("t4 idle next clock", 32'(v[1:0]), 32'd0);
        check("t4 sel held", 32'(sensor_select), 32'd0);
        for (int i = 0; i < 7; i++)
            check($sformatf("t4 sel seq %0d", i), 32'(i < sels.size() ? sels[i] : 99), 32'(exp_seq[i]));
        rd(4'd6, v); check("t4 scan_count", v, 32'd3);

        // Empty mask flags an error, then a mask write starts the scan
        bus_wr(4'd1, 32'd0);
        bus_wr(4'd0, 32'd1);
        repeat (3) @(negedge clock);
        rd(4'd3, v);
        check("t5 mask_empty", 32'(v[20]), 32'd1);
        check("t5 idle", 32'(v[1:0]), 32'd0);
        bus_wr(4'd1, 32'h10);
        @(posedge clock); #1;
        check("t5 switch flush", 32'(decoder_flush), 32'd1);
        check("t5 switch sel", 32'(sensor_select), 32'd4);

        // Asynchronous reset in the middle of a switch
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6 async sel", 32'(sensor_select), 32'd0);
        check("t6 async flush", 32'(decoder_flush), 32'd0);
        check("t6 async done", 32'(scan_done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rd(4'd1, v); check("t6 mask after reset", v, 32'h0000_00FF);
        rd(4'd0, v); check("t6 ctrl after reset", v, 32'd0);
        rd(4'd9, v); check("t6 unmapped", v, 32'hDEAD_BEEF);

        @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
